// File: rtl/roc_encoder_core.sv
// Rank-order encoder: emits pixel indices highest value first (ties: lowest index first).
// Optional feature macro ROC_SKIP_ZERO_EN: zero-valued pixels are never emitted.
module roc_encoder_core #(
    parameter int IMAGE_SIZE      = 7,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PIXEL_BITS-1:0] IMAGE [0:IMAGE_SIZE-1],
    input  logic                  NEW_IMAGE,
    input  logic                  AERIN_CTRL_BUSY,
    input  logic                  FIRST_INFERENCE_DONE,
    output logic [9:0]            NEXT_INDEX,
    output logic                  FOUND_NEXT_INDEX,
    output logic                  ENCODER_RDY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        EMIT    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } state_t;

    localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [PIXEL_BITS-1:0]      PIX_MAX  = PIXEL_BITS'(PIXEL_MAX_VALUE);

    // Clamp a sampled pixel to the declared value range.
    function automatic logic [PIXEL_BITS-1:0] sat_pix(input logic [PIXEL_BITS-1:0] p);
        return (p > PIX_MAX) ? PIX_MAX : p;
    endfunction

    state_t                     state, state_n;
    logic [PIXEL_BITS-1:0]      image_q [0:IMAGE_SIZE-1];
    logic [PIXEL_BITS-1:0]      image_n [0:IMAGE_SIZE-1];
    logic [IMAGE_SIZE-1:0]      used, used_n;
    logic [IMAGE_SIZE_BITS-1:0] scan_idx, scan_idx_n;
    logic                       best_valid, best_valid_n;
    logic [PIXEL_BITS-1:0]      best_val, best_val_n;
    logic [IMAGE_SIZE_BITS-1:0] best_idx, best_idx_n;
    logic [9:0]                 next_index_n;
    logic                       found_n;
    logic                       rdy_n;
    logic [PIXEL_BITS-1:0]      pix;
    logic                       pix_ok;
    logic                       take;

    assign pix = image_q[scan_idx];
`ifdef ROC_SKIP_ZERO_EN
    assign pix_ok = (pix != '0);
`else
    assign pix_ok = 1'b1;
`endif
    // Strict greater-than keeps the lowest index among equal values.
    assign take = !used[scan_idx] && pix_ok && (!best_valid || (pix > best_val));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        image_n      = image_q;
        used_n       = used;
        scan_idx_n   = scan_idx;
        best_valid_n = best_valid;
        best_val_n   = best_val;
        best_idx_n   = best_idx;
        next_index_n = NEXT_INDEX;
        found_n      = 1'b0;
        rdy_n        = ENCODER_RDY;

        case (state)
            IDLE: begin
                rdy_n = 1'b1;
                if (NEW_IMAGE && !FIRST_INFERENCE_DONE) begin
                    for (int i = 0; i < IMAGE_SIZE; i++) begin
                        image_n[i] = sat_pix(IMAGE[i]);
                    end
                    used_n       = '0;
                    scan_idx_n   = '0;
                    best_valid_n = 1'b0;
                    rdy_n        = 1'b0;
                    state_n      = SCAN;
                end
            end
            SCAN: begin
                if (take) begin
                    best_valid_n = 1'b1;
                    best_val_n   = pix;
                    best_idx_n   = scan_idx;
                end
                if (scan_idx == LAST_IDX) begin
                    if (best_valid_n) begin
                        state_n              = EMIT;
                        found_n              = 1'b1;
                        next_index_n         = 10'(best_idx_n);
                        used_n[best_idx_n]   = 1'b1;
                    end else begin
                        state_n = IDLE;
                        rdy_n   = 1'b1;
                    end
                end else begin
                    scan_idx_n = scan_idx + 1'b1;
                end
            end
            EMIT: begin
                state_n = WAIT_HI;
            end
            WAIT_HI: begin
                if (AERIN_CTRL_BUSY) begin
                    state_n = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!AERIN_CTRL_BUSY) begin
                    state_n      = SCAN;
                    scan_idx_n   = '0;
                    best_valid_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
            end
        endcase

        // Abort wins over everything once an encoding is in flight.
        if ((state != IDLE) && FIRST_INFERENCE_DONE) begin
            state_n = IDLE;
            found_n = 1'b0;
            rdy_n   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                image_q[i] <= '0;
            end
            used             <= '0;
            scan_idx         <= '0;
            best_valid       <= 1'b0;
            best_val         <= '0;
            best_idx         <= '0;
            NEXT_INDEX       <= '0;
            FOUND_NEXT_INDEX <= 1'b0;
            ENCODER_RDY      <= 1'b1;
        end else begin
            image_q          <= image_n;
            used             <= used_n;
            scan_idx         <= scan_idx_n;
            best_valid       <= best_valid_n;
            best_val         <= best_val_n;
            best_idx         <= best_idx_n;
            NEXT_INDEX       <= next_index_n;
            FOUND_NEXT_INDEX <= found_n;
            ENCODER_RDY      <= rdy_n;
        end
    end

endmodule

// File: tb/tb_roc_encoder_core.sv
// Directed bench for roc_encoder_core; expected sequences follow ROC_SKIP_ZERO_EN when defined.
module tb_roc_encoder_core;

    localparam int N = 7;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] img [0:N-1];
    logic       NEW_IMAGE = 1'b0;
    logic       AERIN_CTRL_BUSY = 1'b0;
    logic       FIRST_INFERENCE_DONE = 1'b0;
    logic [9:0] NEXT_INDEX;
    logic       FOUND_NEXT_INDEX;
    logic       ENCODER_RDY;

    int n_checks = 0;
    int n_fail   = 0;
    int got[$];
    int first_lat, rdy_cyc, last_strobe;
    bit rdy_seen;

    roc_encoder_core dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .IMAGE                (img),
        .NEW_IMAGE            (NEW_IMAGE),
        .AERIN_CTRL_BUSY      (AERIN_CTRL_BUSY),
        .FIRST_INFERENCE_DONE (FIRST_INFERENCE_DONE),
        .NEXT_INDEX           (NEXT_INDEX),
        .FOUND_NEXT_INDEX     (FOUND_NEXT_INDEX),
        .ENCODER_RDY          (ENCODER_RDY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int exp[$]);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s_idx%0d", tag, i), got[i], exp[i]);
        end
    endtask

    task automatic accept(input int px[$]);
        for (int i = 0; i < N; i++) img[i] = 8'(px[i]);
        NEW_IMAGE = 1'b1;
        step();
        NEW_IMAGE = 1'b0;
        check("accept_rdy_low", int'(ENCODER_RDY), 0);
    endtask

    // Plays the AER controller: BUSY rises 1 cycle after a strobe and stays up 3 cycles.
    task automatic run_enc(input int stall_after, input int abort_after,
                           input int inject_cyc, input int max_cyc);
        int hold;
        hold = -1;
        got.delete();
        first_lat = -1; rdy_cyc = -1; last_strobe = -1; rdy_seen = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            step();
            NEW_IMAGE = 1'b0;
            FIRST_INFERENCE_DONE = 1'b0;
            if (hold >= 0) begin
                hold++;
                if (hold == 1) AERIN_CTRL_BUSY = 1'b1;
                if (hold == 4) begin
                    AERIN_CTRL_BUSY = 1'b0;
                    hold = -1;
                end
            end
            if (FOUND_NEXT_INDEX) begin
                got.push_back(int'(NEXT_INDEX));
                last_strobe = cyc;
                if (first_lat < 0) first_lat = cyc;
                if (got.size() == abort_after) FIRST_INFERENCE_DONE = 1'b1;
                else if (got.size() != stall_after) hold = 0;
            end
            if (cyc == inject_cyc) begin
                NEW_IMAGE = 1'b1;
                img[0] = 8'd255; img[1] = 8'd0; img[2] = 8'd254; img[3] = 8'd1;
                img[4] = 8'd253; img[5] = 8'd2; img[6] = 8'd252;
            end
            if (ENCODER_RDY) begin
                rdy_seen = 1'b1;
                rdy_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic count_quiet(input int cycles, output int strobes);
        strobes = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (FOUND_NEXT_INDEX) strobes++;
        end
    endtask

    initial begin
        int main_img[$]  = '{10, 200, 50, 200, 0, 7, 255};
        int equal_img[$] = '{9, 9, 9, 9, 9, 9, 9};
        int zero_img[$]  = '{0, 0, 0, 0, 0, 0, 0};
        int seq_all[$]   = '{0, 1, 2, 3, 4, 5, 6};
`ifdef ROC_SKIP_ZERO_EN
        int seq_main[$]  = '{6, 1, 3, 2, 0, 5};
        int seq_zero[$]  = '{};
`else
        int seq_main[$]  = '{6, 1, 3, 2, 0, 5, 4};
        int seq_zero[$]  = '{0, 1, 2, 3, 4, 5, 6};
`endif
        int strobes;

        for (int i = 0; i < N; i++) img[i] = 8'd0;
        step(); step();
        check("in_reset_rdy", int'(ENCODER_RDY), 1);
        RST = 1'b0;
        step(); step();
        check("reset_rdy", int'(ENCODER_RDY), 1);
        check("reset_found", int'(FOUND_NEXT_INDEX), 0);
        check("reset_index", int'(NEXT_INDEX), 0);

        // Main image, full encoding
        accept(main_img);
        run_enc(0, 0, 0, 300);
        check("main_first_latency", first_lat, N);
        check_seq("main", seq_main);
        check("main_rdy_after", int'(rdy_seen), 1);
        check("main_index_held", int'(NEXT_INDEX), seq_main[seq_main.size()-1]);

        // All-equal image: lowest index wins each tie
        accept(equal_img);
        run_enc(0, 0, 0, 300);
        check_seq("equal", seq_all);
        check("equal_rdy_after", int'(rdy_seen), 1);

        // All-zero image
        accept(zero_img);
        run_enc(0, 0, 0, 300);
        check_seq("zero", seq_zero);
        check("zero_rdy_after", int'(rdy_seen), 1);

        // BUSY never rises after the first strobe: no second strobe
        accept(equal_img);
        run_enc(1, 0, 0, 80);
        check_seq("stall", '{0});
        check("stall_not_rdy", int'(rdy_seen), 0);
        FIRST_INFERENCE_DONE = 1'b1;
        step();
        FIRST_INFERENCE_DONE = 1'b0;
        check("stall_abort_rdy", int'(ENCODER_RDY), 1);
        check("stall_abort_found", int'(FOUND_NEXT_INDEX), 0);

        // Abort after the second strobe
        accept(main_img);
        run_enc(0, 2, 0, 300);
        check_seq("abort", '{6, 1});
        check("abort_rdy_next_cycle", rdy_cyc, last_strobe + 1);
        count_quiet(30, strobes);
        check("abort_no_more_strobes", strobes, 0);
        accept(main_img);
        run_enc(0, 0, 0, 300);
        check_seq("restart", seq_main);

        // Abort in IDLE outranks NEW_IMAGE
        for (int i = 0; i < N; i++) img[i] = 8'(main_img[i]);
        NEW_IMAGE = 1'b1;
        FIRST_INFERENCE_DONE = 1'b1;
        step();
        NEW_IMAGE = 1'b0;
        FIRST_INFERENCE_DONE = 1'b0;
        check("idle_abort_rdy", int'(ENCODER_RDY), 1);
        count_quiet(N + 4, strobes);
        check("idle_abort_no_strobe", strobes, 0);
        check("idle_abort_still_rdy", int'(ENCODER_RDY), 1);

        // NEW_IMAGE plus a changed IMAGE during SCAN must not disturb the encoding
        accept(main_img);
        run_enc(0, 0, 3, 300);
        check_seq("inject", seq_main);

        // Asynchronous reset while in WAIT_LO
        accept(main_img);
        strobes = 0;
        for (int i = 0; i < 20 && !FOUND_NEXT_INDEX; i++) step();
        check("rst_pre_strobe", int'(FOUND_NEXT_INDEX), 1);
        step();
        AERIN_CTRL_BUSY = 1'b1;
        step(); step();
        check("rst_pre_index", int'(NEXT_INDEX), 6);
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_rdy", int'(ENCODER_RDY), 1);
        check("rst_async_found", int'(FOUND_NEXT_INDEX), 0);
        check("rst_async_index", int'(NEXT_INDEX), 0);
        #1;
        RST = 1'b0;
        AERIN_CTRL_BUSY = 1'b0;
        count_quiet(N + 4, strobes);
        check("rst_no_strobe", strobes, 0);
        check("rst_idle_rdy", int'(ENCODER_RDY), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/roc_encoder_core.md
ROC_ENCODER_CORE -- requirements
Module: ROC_encoder

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: CLK input, 1 bit, rising-edge clock; RST input, 1 bit, asynchronous active-high reset.
REQ-002 Parameter IMAGE_SIZE, default 7: number of pixels.
REQ-003 Parameter IMAGE_SIZE_BITS, default $clog2(IMAGE_SIZE): internal pixel-index counter width.
REQ-004 Parameter PIXEL_MAX_VALUE, default 255: largest pixel value.
REQ-005 Parameter PIXEL_BITS, default $clog2(PIXEL_MAX_VALUE): pixel width.
REQ-006 IMAGE  input  unpacked [0:IMAGE_SIZE-1] of PIXEL_BITS  image pixels, sampled only on acceptance.
REQ-007 NEW_IMAGE  input  1  request to encode IMAGE.
REQ-008 AERIN_CTRL_BUSY  input  1  downstream AER controller busy; acts as acknowledge.
REQ-009 FIRST_INFERENCE_DONE  input  1  abort request; the network has already decided.
REQ-010 NEXT_INDEX  output  10  index of the pixel being emitted, zero-extended.
REQ-011 FOUND_NEXT_INDEX  output  1  one-cycle strobe: NEXT_INDEX is valid.
REQ-012 ENCODER_RDY  output  1  high when idle and able to accept an image.

Function
REQ-013 SHALL emit pixel indices in rank order: highest value first; on equal values, lowest index first.
REQ-014 Each pixel index SHALL be emitted at most once per image, tracked with a per-pixel used-flag vector.
REQ-015 States: IDLE, SCAN, EMIT, WAIT_HI, WAIT_LO; all outputs registered.
REQ-016 IDLE: ENCODER_RDY=1. NEW_IMAGE=1 at an edge latches IMAGE, clears the used flags, sets ENCODER_RDY=0 and enters SCAN at index 0.
REQ-017 NEW_IMAGE SHALL be ignored outside IDLE; the latched image SHALL be immune to later IMAGE changes.
REQ-018 SCAN examines one pixel per cycle for exactly IMAGE_SIZE cycles, keeping the best unused candidate with a strict greater-than compare.
REQ-019 After SCAN: if a candidate exists, go to EMIT; if none exists, return to IDLE with ENCODER_RDY=1 on the next edge.
REQ-020 EMIT lasts one cycle: FOUND_NEXT_INDEX=1, NEXT_INDEX=candidate, candidate marked used; then go to WAIT_HI.
REQ-021 FOUND_NEXT_INDEX SHALL first be high in the (IMAGE_SIZE+1)th cycle after the accepting edge.
REQ-022 NEXT_INDEX SHALL hold its value until the next EMIT.
REQ-023 WAIT_HI waits for AERIN_CTRL_BUSY=1, then goes to WAIT_LO.
REQ-024 WAIT_LO waits for AERIN_CTRL_BUSY=0, then goes to SCAN at index 0.
REQ-025 WAIT_HI and WAIT_LO SHALL have no timeout.
REQ-026 FIRST_INFERENCE_DONE=1 sampled in any non-IDLE state SHALL force IDLE on that edge: no further FOUND_NEXT_INDEX, ENCODER_RDY=1.
REQ-027 In IDLE, FIRST_INFERENCE_DONE=1 has priority over NEW_IMAGE: the image is not accepted.

Reset
REQ-028 On RST the block SHALL enter IDLE at once, from any state, including mid-encoding.
REQ-029 Reset values: NEXT_INDEX=0, FOUND_NEXT_INDEX=0, ENCODER_RDY=1, used flags cleared, latched image zero.

Configuration
REQ-030 Macro ROC_SKIP_ZERO_EN defined: pixels of value 0 SHALL never be emitted; a best candidate of value 0 counts as "no candidate" and ends the encoding.
REQ-031 Macro ROC_SKIP_ZERO_EN undefined: every pixel, including zero-valued ones, SHALL be emitted.

Verification
REQ-032 Scenario: reset, then idle → ENCODER_RDY=1, FOUND_NEXT_INDEX=0, NEXT_INDEX=0.
REQ-033 Scenario: IMAGE={10,200,50,200,0,7,255}; 1-cycle NEW_IMAGE; bench raises BUSY 1 cycle after each strobe and holds it 3 cycles → NEXT_INDEX sequence 6,1,3,2,0,5,4; ENCODER_RDY=1 afterwards.
REQ-034 Scenario: the same image with ROC_SKIP_ZERO_EN defined → sequence 6,1,3,2,0,5; index 4 never emitted.
REQ-035 Scenario: all-equal image {9×7} → sequence 0..6; BUSY held low after the first strobe → no second strobe ever.
REQ-036 Scenario: FIRST_INFERENCE_DONE pulsed after the 2nd strobe → no further strobes; ENCODER_RDY=1 on the next cycle; a subsequent NEW_IMAGE restarts from the top rank.
REQ-037 Scenario: RST pulsed in WAIT_LO → reset values at once; NEW_IMAGE pulsed mid-encoding → ignored, sequence unchanged.
